// File: rtl/cart_load_sequencer.sv
// Cartridge slot selection and reload sequencing: debounced front-panel button,
// short/long press classification, loader handshake and NES core reset hold-off.
`timescale 1ns/1ps
module cart_load_sequencer #(
  parameter int DEBOUNCE_BITS     = 16,
  parameter int LONG_PRESS_CYCLES = 21000000,
  parameter int NUM_SLOTS         = 8,
  parameter int HOLD_CYCLES       = 256,
  parameter int DONE_TIMEOUT      = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       btn_n,
  input  logic       load_done,
  output logic       reload,
  output logic [3:0] index,
  output logic       nes_reset,
  output logic       busy
);

  localparam int PW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [PW-1:0] P_MAX     = PW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(DONE_TIMEOUT - 1);
  localparam logic [3:0]    SLOT_LAST = 4'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_BOOT, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_HOLD, S_RUN
  } state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2;
  logic                  r_deb, r_deb_q;
  logic [DEBOUNCE_BITS-1:0] r_db_cnt;
  logic [PW-1:0]         r_ptmr;
  logic [TW-1:0]         r_to_cnt;
  logic [HW-1:0]         r_hold_cnt;

  logic       w_press, w_release, w_long;
  logic [3:0] w_idx_next;

  assign w_press    = ~r_deb & r_deb_q;
  assign w_release  = r_deb & ~r_deb_q;
  assign w_long     = (r_ptmr == P_MAX);
  assign w_idx_next = (index == SLOT_LAST) ? 4'd0 : index + 4'd1;

  // Level flips on the 2^DEBOUNCE_BITS-th consecutive clock of disagreement.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_deb    <= 1'b1;
      r_deb_q  <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      if (r_sync2 == r_deb) begin
        r_db_cnt <= '0;
      end else if (&r_db_cnt) begin
        r_deb    <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptmr <= '0;
    end else if (w_press) begin
      r_ptmr <= '0;
    end else if (!r_deb && r_ptmr != P_MAX) begin
      r_ptmr <= r_ptmr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_BOOT;
      reload     <= 1'b0;
      index      <= 4'd0;
      nes_reset  <= 1'b1;
      busy       <= 1'b1;
      r_to_cnt   <= '0;
      r_hold_cnt <= '0;
    end else begin
      reload <= 1'b0;
      if (!pll_locked && r_state != S_BOOT) begin
        // Lock loss keeps index so the relock reloads the same slot.
        r_state   <= S_BOOT;
        nes_reset <= 1'b1;
        busy      <= 1'b1;
      end else begin
        case (r_state)
          S_BOOT: if (pll_locked) r_state <= S_ISSUE;
          S_ISSUE: begin
            reload   <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= S_WAIT_LOW;
          end
          S_WAIT_LOW: begin
            if (!load_done || r_to_cnt == TO_LAST) r_state <= S_WAIT_HIGH;
            else r_to_cnt <= r_to_cnt + TW'(1);
          end
          S_WAIT_HIGH: begin
            if (load_done) begin
              r_hold_cnt <= '0;
              r_state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state   <= S_RUN;
              nes_reset <= 1'b0;
              busy      <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HW'(1);
            end
          end
          S_RUN: begin
            if (w_release) begin
              if (!w_long) index <= w_idx_next;
              r_state   <= S_ISSUE;
              nes_reset <= 1'b1;
              busy      <= 1'b1;
            end
          end
          default: r_state <= S_BOOT;
        endcase
      end
    end
  end

endmodule

// File: doc/cart_load_sequencer.md
Name: cart_load_sequencer

Overview:
- Controls cartridge (ROM slot) selection and reload for the NES top level.
- Debounces the single front-panel button and classifies each press as short (advance to next slot) or long (reload current slot).
- Issues the reload pulse and slot index to the flash loader (main_mem) and tracks its load_done handshake.
- Holds the NES core in reset until a load has finished and a post-load hold period has elapsed.
- Replaces the ad-hoc edge-detect reload logic at the top level.

Parameters:
- DEBOUNCE_BITS, 16: debounce counter width; input must be stable for 2^DEBOUNCE_BITS clocks.
- LONG_PRESS_CYCLES, 21000000: press duration at or above which a press is long (about 1 s at 21 MHz).
- NUM_SLOTS, 8: number of ROM slots, range 1..16; index wraps at NUM_SLOTS.
- HOLD_CYCLES, 256: clocks nes_reset stays high after load_done rises; minimum 1.
- DONE_TIMEOUT, 64: clocks to wait for load_done to fall after reload before treating the load as started anyway.

Ports:
- clock  in  1  system clock (PLL output).
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock, already registered into the clock domain.
- btn_n  in  1  raw button, active-low (pressed = 0), asynchronous to clock.
- load_done  in  1  from main_mem; low while loading, high when the image is ready.
- reload  out  1  one-clock pulse to main_mem starting a load.
- index  out  4  slot number to main_mem; stable from the reload pulse until load_done rises.
- nes_reset  out  1  reset to the NES core and audio DAC, active-high.
- busy  out  1  high in every state except RUN.

Behaviour:
- Reset (reset_n low, asynchronous) forces:
  - state = BOOT, reload = 0, index = 0, nes_reset = 1, busy = 1.
  - All counters cleared; synchronizer and debounced level set to 1 (released).
- btn_n passes through a 2-flop synchronizer.
- Debounce: the debounced level changes only after the synchronized input has differed from it for 2^DEBOUNCE_BITS consecutive clocks. The counter clears whenever the input equals the debounced level.
- Press timer: counts clocks while the debounced level is 0 and saturates at LONG_PRESS_CYCLES. It clears on the debounced falling edge (press).
- Press classification happens on the debounced rising edge (release): long if timer = LONG_PRESS_CYCLES, otherwise short.
- FSM:
  - BOOT: wait for pll_locked = 1, then go to ISSUE.
  - ISSUE: assert reload for exactly one clock, clear the timeout counter, go to WAIT_LOW. index is already valid in this cycle.
  - WAIT_LOW: go to WAIT_HIGH when load_done = 0, or when the timeout counter reaches DONE_TIMEOUT−1 (covers a loader that finishes instantly).
  - WAIT_HIGH: on load_done = 1, clear the hold counter and go to HOLD.
  - HOLD: count; after HOLD_CYCLES clocks in HOLD, go to RUN.
  - RUN: nes_reset = 0, busy = 0.
    - Short release: index ← (index+1 == NUM_SLOTS) ? 0 : index+1; go to ISSUE.
    - Long release: index unchanged; go to ISSUE.
    - Entering ISSUE drives nes_reset = 1 in the same cycle as the state transition.
- nes_reset is 1 in every state except RUN, and is registered.
- Button releases outside RUN are discarded and not queued. The debounce and press timer keep running.
- pll_locked falling in any state other than BOOT: go to BOOT and assert nes_reset. index is retained, so the next load reuses the current slot.
- Reset mid-load: nes_reset = 1 immediately. After reset, index returns to 0 and loading restarts from BOOT.
- Latency from RUN to reload: exactly 2 clocks after the debounced release edge (RUN→ISSUE registered, then reload high).
- Button chatter shorter than 2^DEBOUNCE_BITS clocks produces no event.

Test Plan:
- Boot: reset_n low 5 clocks then high, pll_locked high at clock 10, loader model drops load_done 3 clocks after reload and raises it 100 clocks later → exactly one reload pulse at index 0; nes_reset falls HOLD_CYCLES (256) clocks after load_done rises; busy = 0.
- Short press (DEBOUNCE_BITS = 4 for sim): hold btn_n low 1000 clocks then release → index 0→1, one reload pulse 2 clocks after the debounced release, nes_reset high throughout the reload.
- Wrap and long press (NUM_SLOTS = 3, LONG_PRESS_CYCLES = 500):
  - Three short presses → index sequence 1, 2, 0.
  - A 600-clock press → reload pulse with index unchanged.
- Bounce: toggle btn_n every 5 clocks for 200 clocks with debounce 2^4 → no reload, index stable. A press during WAIT_HIGH → ignored, no second reload.
- Instant loader (load_done held high) → WAIT_LOW times out after DONE_TIMEOUT clocks, then HOLD, then RUN.
- Lock and reset: pll_locked dropped in RUN → nes_reset = 1 next clock; pll_locked restored → reload with the same index. reset_n pulsed during HOLD → all outputs return to reset values asynchronously.
